// File: rtl/systolic_seq_ctrl_if.sv
// Control/handshake and enable bundle between the systolic array host and its phase sequencer.
// master = host side issuing start/abort; slave = sequencer driving enables and status.
interface systolic_seq_ctrl_if #(
    parameter int TILE_W = 8,
    parameter int ADDR_W = 16
);
    logic              start;
    logic [TILE_W-1:0] num_tiles;
    logic              reuse_weights;
    logic              abort;
    logic              busy;
    logic              done;
    logic [TILE_W-1:0] tile_idx;
    logic              weight_buffer_load_en;
    logic              write_weight_en;
    logic              weight_buffer_out_en;
    logic              input_buffer_load_en;
    logic              input_buffer_out_en;
    logic              output_buffer_load_en;
    logic              output_buffer_out_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_sel;

    modport master (
        output start, num_tiles, reuse_weights, abort,
        input  busy, done, tile_idx,
        input  weight_buffer_load_en, write_weight_en, weight_buffer_out_en,
        input  input_buffer_load_en, input_buffer_out_en,
        input  output_buffer_load_en, output_buffer_out_en,
        input  rd_addr, rd_sel
    );

    modport slave (
        input  start, num_tiles, reuse_weights, abort,
        output busy, done, tile_idx,
        output weight_buffer_load_en, write_weight_en, weight_buffer_out_en,
        output input_buffer_load_en, input_buffer_out_en,
        output output_buffer_load_en, output_buffer_out_en,
        output rd_addr, rd_sel
    );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Multi-tile phase sequencer for the systolic array: LOAD_W, STREAM, WAIT, COLLECT, READOUT per tile,
// with optional weight reuse across tiles. Outputs decode registered state/counter combinationally.
module systolic_seq_ctrl #(
    parameter int ARRAYHEIGHT = 4,
    parameter int ARRAYWIDTH  = 4,
    parameter int DSP_DELAY   = 1,
    parameter int TILE_W      = 8,
    parameter int ADDR_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    systolic_seq_ctrl_if.slave  bus
);
    localparam int LEN_H    = ARRAYHEIGHT;
    localparam int LEN_WAIT = DSP_DELAY * (ARRAYWIDTH - 1);
    localparam int LEN_COLL = 2 * DSP_DELAY * ARRAYHEIGHT;
    localparam int MAX_A    = (LEN_H > LEN_WAIT) ? LEN_H : LEN_WAIT;
    localparam int MAX_LEN  = (MAX_A > LEN_COLL) ? MAX_A : LEN_COLL;
    localparam int CNT_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CNT_W-1:0] LAST_H    = CNT_W'(LEN_H - 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((LEN_WAIT == 0) ? 0 : LEN_WAIT - 1);
    localparam logic [CNT_W-1:0] LAST_COLL = CNT_W'(LEN_COLL - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_WAIT,
        S_COLLECT,
        S_READOUT,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TILE_W-1:0] tile_q, tile_d;
    logic [TILE_W-1:0] ntiles_q, ntiles_d;
    logic              reuse_q, reuse_d;
    logic              more_tiles;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            tile_q   <= '0;
            ntiles_q <= '0;
            reuse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tile_q   <= tile_d;
            ntiles_q <= ntiles_d;
            reuse_q  <= reuse_d;
        end
    end

    // Extra bit so tile_idx+1 cannot wrap when num_tiles is at its maximum.
    assign more_tiles = ({1'b0, tile_q} + (TILE_W+1)'(1)) < {1'b0, ntiles_q};

    always_comb begin
        state_d  = state_q;
        tile_d   = tile_q;
        ntiles_d = ntiles_q;
        reuse_d  = reuse_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.abort) begin
                    ntiles_d = bus.num_tiles;
                    reuse_d  = bus.reuse_weights;
                    state_d  = (bus.num_tiles == '0) ? S_DONE : S_LOAD_W;
                end
            end
            S_LOAD_W: if (cnt_q == LAST_H) state_d = S_STREAM;
            S_STREAM: if (cnt_q == LAST_H) state_d = (LEN_WAIT == 0) ? S_COLLECT : S_WAIT;
            S_WAIT:   if (cnt_q == LAST_WAIT) state_d = S_COLLECT;
            S_COLLECT: if (cnt_q == LAST_COLL) state_d = S_READOUT;
            S_READOUT: begin
                if (cnt_q == LAST_H) begin
                    if (more_tiles) begin
                        tile_d  = tile_q + TILE_W'(1);
                        state_d = reuse_q ? S_STREAM : S_LOAD_W;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                tile_d  = '0;
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
            tile_d  = '0;
        end

        // READOUT->STREAM under reuse is also a state change, so the counter restarts there too.
        if (state_d != state_q || state_q == S_IDLE || state_q == S_DONE) cnt_d = '0;
        else                                                               cnt_d = cnt_q + CNT_W'(1);
    end

    always_comb begin
        bus.busy                  = (state_q != S_IDLE);
        bus.done                  = (state_q == S_DONE);
        bus.tile_idx              = tile_q;
        bus.weight_buffer_load_en = (state_q == S_LOAD_W);
        bus.write_weight_en       = (state_q == S_STREAM);
        bus.weight_buffer_out_en  = (state_q == S_STREAM);
        bus.input_buffer_load_en  = (state_q == S_STREAM);
        bus.input_buffer_out_en   = (state_q == S_WAIT) || (state_q == S_COLLECT);
        bus.output_buffer_load_en = (state_q == S_COLLECT);
        bus.output_buffer_out_en  = (state_q == S_READOUT);
        bus.rd_sel                = (state_q == S_STREAM);
        bus.rd_addr               = '0;
        if (state_q == S_LOAD_W || state_q == S_STREAM) begin
            bus.rd_addr = ADDR_W'(32'(tile_q) * 32'(2 * ARRAYHEIGHT)
                                  + ((state_q == S_STREAM) ? 32'(ARRAYHEIGHT) : 32'd0)
                                  + 32'(cnt_q));
        end
    end
endmodule
